// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD and 7-segment constants for the display scanner
package bcd_pkg;

    localparam int BCD_W = 4;

    // Segment order {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to 7-segment decoder, dash for 10..15
module bcd_to_seg7
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [6:0]       seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// rtl/bcd_seg_scanner.sv - shadowed BCD digits scanned onto a multiplexed common-cathode display
module bcd_seg_scanner
    import bcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
    input  logic                        load,
    input  logic                        blank_lz,
    output logic [6:0]                  seg,
    output logic [NUM_DIGITS-1:0]       digit_en,
    output logic                        err
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [BCD_W*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [PRE_W-1:0]            presc_q, presc_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [6:0]                  seg_q, seg_d;
    logic [NUM_DIGITS-1:0]       digit_en_q, digit_en_d;
    logic                        err_q, err_d;

    logic [BCD_W-1:0]            cur_digit;
    logic [6:0]                  dec_seg;
    logic [NUM_DIGITS-1:0]       upper_zero;
    logic                        cur_blank;
    logic                        run_zero;

    // upper_zero[i]: digits i..N-1 are all zero; an invalid code breaks the run
    always_comb begin
        cur_digit  = '0;
        cur_blank  = 1'b0;
        err_d      = 1'b0;
        upper_zero = '0;
        run_zero   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero      = run_zero && (shadow_q[BCD_W*i +: BCD_W] == '0);
            upper_zero[i] = run_zero;
            err_d         = err_d || (shadow_q[BCD_W*i +: BCD_W] > 4'd9);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = shadow_q[BCD_W*i +: BCD_W];
                cur_blank = blank_lz && (i != 0) && upper_zero[i];
            end
        end
    end

    bcd_to_seg7 u_dec (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

    always_comb begin
        shadow_d   = load ? bcd_in : shadow_q;
        presc_d    = presc_q + PRE_W'(1);
        idx_d      = idx_q;
        seg_d      = cur_blank ? SEG_BLANK : dec_seg;
        digit_en_d = NUM_DIGITS'(1) << idx_q;
        if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_q   <= '0;
            presc_q    <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            digit_en_q <= '0;
            err_q      <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            digit_en_q <= digit_en_d;
            err_q      <= err_d;
        end
    end

    assign seg      = seg_q;
    assign digit_en = digit_en_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// tb/tb_bcd_seg_scanner.sv - self-checking bench: directed vector table plus randomized model comparison
module tb_bcd_seg_scanner;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        blank_lz;
    logic [15:0] bcd_in;
    logic [6:0]  seg0, seg1;
    logic [3:0]  en0, en1;
    logic        err0, err1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_seg_scanner #(.NUM_DIGITS(N), .SCAN_DIV(2)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
        .seg(seg0), .digit_en(en0), .err(err0)
    );

    bcd_seg_scanner #(.NUM_DIGITS(N), .SCAN_DIV(1)) dut_fast (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .blank_lz(blank_lz),
        .seg(seg1), .digit_en(en1), .err(err1)
    );

    typedef struct {
        logic        rst;
        logic        load;
        logic [15:0] bcd;
        logic        bl;
        logic [6:0]  seg;
        logic [3:0]  en;
        logic        err;
    } vec_t;

    vec_t        vt[$];
    logic [6:0]  seg_tab[10];
    logic [15:0] m_sh[2];
    int          m_cnt[2];

    function automatic vec_t mk(logic r, logic l, logic [15:0] b, logic bl,
                                logic [6:0] s, logic [3:0] e, logic er);
        vec_t v;
        v.rst = r; v.load = l; v.bcd = b; v.bl = bl; v.seg = s; v.en = e; v.err = er;
        return v;
    endfunction

    function automatic int nib(logic [15:0] sh, int i);
        return int'((sh >> (4 * i)) & 16'hF);
    endfunction

    function automatic logic [6:0] ref_seg(logic [15:0] sh, int idx, logic bl);
        int d = nib(sh, idx);
        if (d > 9) return 7'h40;
        if (bl && idx > 0 && (sh >> (4 * idx)) == 16'h0) return 7'h00;
        return seg_tab[d];
    endfunction

    function automatic logic ref_err(logic [15:0] sh);
        for (int j = 0; j < N; j++) if (nib(sh, j) > 9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: digit shown at an edge is (edges since reset / SCAN_DIV) mod N
    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            int div = (k == 0) ? 2 : 1;
            logic [6:0] es;
            logic [3:0] ee;
            logic       er;
            if (!rst) begin
                es = 7'h00; ee = 4'h0; er = 1'b0;
                m_sh[k] = 16'h0; m_cnt[k] = 0;
            end else begin
                int idx = (m_cnt[k] / div) % N;
                es = ref_seg(m_sh[k], idx, blank_lz);
                ee = 4'(1 << idx);
                er = ref_err(m_sh[k]);
                m_cnt[k]++;
                if (load) m_sh[k] = bcd_in;
            end
            chk($sformatf("model_seg[div%0d]", div), {25'h0, (k == 0) ? seg0 : seg1}, {25'h0, es});
            chk($sformatf("model_en[div%0d]", div),  {28'h0, (k == 0) ? en0 : en1},   {28'h0, ee});
            chk($sformatf("model_err[div%0d]", div), {31'h0, (k == 0) ? err0 : err1}, {31'h0, er});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_check();
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        m_sh    = '{16'h0, 16'h0};
        m_cnt   = '{0, 0};

        // reset, scan of 1234, blanking, invalid code, reset mid-scan (SCAN_DIV=2 instance)
        vt.push_back(mk(0, 0, 16'h0000, 0, 7'h00, 4'h0, 0));
        vt.push_back(mk(0, 0, 16'h0000, 0, 7'h00, 4'h0, 0));
        vt.push_back(mk(0, 1, 16'h1234, 0, 7'h00, 4'h0, 0));
        vt.push_back(mk(1, 0, 16'h0000, 0, 7'h3F, 4'h1, 0));
        vt.push_back(mk(1, 1, 16'h1234, 0, 7'h3F, 4'h1, 0));
        vt.push_back(mk(1, 0, 16'h0000, 0, 7'h4F, 4'h2, 0));
        vt.push_back(mk(1, 0, 16'h0000, 0, 7'h4F, 4'h2, 0));
        vt.push_back(mk(1, 0, 16'h0000, 0, 7'h5B, 4'h4, 0));
        vt.push_back(mk(1, 0, 16'h0000, 0, 7'h5B, 4'h4, 0));
        vt.push_back(mk(1, 0, 16'h0000, 0, 7'h06, 4'h8, 0));
        vt.push_back(mk(1, 0, 16'h0000, 0, 7'h06, 4'h8, 0));
        vt.push_back(mk(1, 0, 16'h0000, 0, 7'h66, 4'h1, 0));
        vt.push_back(mk(1, 0, 16'h0000, 0, 7'h66, 4'h1, 0));
        vt.push_back(mk(1, 1, 16'h0050, 1, 7'h4F, 4'h2, 0));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h6D, 4'h2, 0));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h00, 4'h4, 0));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h00, 4'h4, 0));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h00, 4'h8, 0));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h00, 4'h8, 0));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h3F, 4'h1, 0));
        vt.push_back(mk(1, 1, 16'h0000, 1, 7'h3F, 4'h1, 0));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h00, 4'h2, 0));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h00, 4'h2, 0));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h00, 4'h4, 0));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h00, 4'h4, 0));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h00, 4'h8, 0));
        vt.push_back(mk(1, 1, 16'h12A4, 1, 7'h00, 4'h8, 0));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h66, 4'h1, 1));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h66, 4'h1, 1));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h40, 4'h2, 1));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h40, 4'h2, 1));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h5B, 4'h4, 1));
        vt.push_back(mk(1, 1, 16'h0A00, 1, 7'h5B, 4'h4, 1));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h00, 4'h8, 1));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h00, 4'h8, 1));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h3F, 4'h1, 1));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h3F, 4'h1, 1));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h3F, 4'h2, 1));
        vt.push_back(mk(1, 1, 16'h1234, 1, 7'h3F, 4'h2, 1));
        vt.push_back(mk(1, 0, 16'h0000, 1, 7'h5B, 4'h4, 0));
        vt.push_back(mk(0, 0, 16'h0000, 0, 7'h00, 4'h0, 0));
        vt.push_back(mk(1, 0, 16'h0000, 0, 7'h3F, 4'h1, 0));
        vt.push_back(mk(1, 0, 16'h0000, 0, 7'h3F, 4'h1, 0));
        vt.push_back(mk(1, 0, 16'h0000, 0, 7'h3F, 4'h2, 0));

        rst = 1'b0; load = 1'b0; blank_lz = 1'b0; bcd_in = 16'h0;
        for (int v = 0; v < vt.size(); v++) begin
            rst = vt[v].rst; load = vt[v].load; bcd_in = vt[v].bcd; blank_lz = vt[v].bl;
            tick();
            chk($sformatf("vec%0d_seg", v), {25'h0, seg0}, {25'h0, vt[v].seg});
            chk($sformatf("vec%0d_en", v),  {28'h0, en0},  {28'h0, vt[v].en});
            chk($sformatf("vec%0d_err", v), {31'h0, err0}, {31'h0, vt[v].err});
        end

        // load held high with bcd_in changing every edge
        rst = 1'b1; load = 1'b1;
        for (int c = 0; c < 40; c++) begin
            bcd_in   = 16'($urandom);
            blank_lz = 1'($urandom_range(0, 1));
            tick();
        end

        // randomized traffic, biased toward leading zeros and occasional resets
        for (int c = 0; c < 1500; c++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 3))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h0FFF;
                2:       mask = 16'h00FF;
                default: mask = 16'h000F;
            endcase
            rst      = ($urandom_range(0, 39) != 0);
            load     = ($urandom_range(0, 3) == 0);
            bcd_in   = 16'($urandom) & mask;
            blank_lz = 1'($urandom_range(0, 1));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
